wave_addr_seq: RTL and testbench

- Parametrised successor to the two-stage neuron address controller.
- Generates skewed (wavefront) read addresses for STAGES pipelined neuron stages walking a DEPTH-entry weight/activation memory.
- Stage k reads the address stage 0 read k cycles earlier.
- Adds a start/busy/done handshake, per-stage valid flags (no X on outputs), stall support and re-arming without reset.

---
 rtl/nn_pkg.sv | 15 +
 rtl/wave_lane.sv | 27 ++
 rtl/wave_addr_seq.sv | 133 +++++++++++++
 tb/tb_wave_addr_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and width helpers for the neuron address sequencers.
package nn_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_t;

    // Never returns 0 so single-bit quantities still get a real vector.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wave_lane.sv
// One skewed lane: maps the step counter and a fixed offset K to an address/valid pair.
module wave_lane
    import nn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int K     = 0,
    parameter int AW    = width_of(DEPTH),
    parameter int TW    = width_of(DEPTH + 1)
) (
    input  logic [TW-1:0] t,
    output logic [AW-1:0] addr,
    output logic          vld
);

    localparam logic [TW-1:0] OFS = TW'(K);
    localparam logic [TW-1:0] LIM = TW'(DEPTH - 1);

    logic [TW:0] sub;

    // The borrow bit stands in for t >= K, avoiding a constant compare when K == 0.
    always_comb begin
        sub  = {1'b0, t} - {1'b0, OFS};
        vld  = !sub[TW] && (sub[TW-1:0] <= LIM);
        addr = vld ? sub[AW-1:0] : '0;
    end

endmodule

// File: rtl/wave_addr_seq.sv
// Wavefront read-address sequencer for STAGES skewed neuron stages over a DEPTH-entry memory.
// Optional WAVE_SEQ_REPEAT_EN adds multi-pass runs (passes / pass_idx ports).
//
//  state    | meaning
//  SEQ_IDLE | waiting for start, outputs quiet
//  SEQ_RUN  | stepping t from 0 to LAST, registered lane outputs
//  SEQ_DONE | single cycle, done pulse, then back to idle
module wave_addr_seq
    import nn_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int STAGES = 2,
    localparam int AW    = width_of(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 finished,
    output logic [STAGES*AW-1:0] addr,
    output logic [STAGES-1:0]    addr_vld
`ifdef WAVE_SEQ_REPEAT_EN
    ,
    input  logic [7:0]           passes,
    output logic [7:0]           pass_idx
`endif
);

    localparam int TW = width_of(DEPTH + STAGES);
    localparam logic [TW-1:0] LAST = TW'(DEPTH + STAGES - 2);

    seq_state_t state, state_n;
    logic [TW-1:0] t, t_n;
    logic accept;
    logic last_pass;
    logic [STAGES*AW-1:0] lane_addr;
    logic [STAGES-1:0] lane_vld;

`ifdef WAVE_SEQ_REPEAT_EN
    logic [7:0] passes_q;
    logic [7:0] pass_n;
    assign last_pass = (pass_idx == passes_q);
`else
    assign last_pass = 1'b1;
`endif

    always_comb begin
        state_n = state;
        t_n     = t;
        accept  = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) begin
                    state_n = SEQ_RUN;
                    t_n     = '0;
                    accept  = 1'b1;
                end
            end
            SEQ_RUN: begin
                if (!stall) begin
                    if (t == LAST) begin
                        t_n = '0;
                        if (last_pass) state_n = SEQ_DONE;
                    end else begin
                        t_n = t + TW'(1);
                    end
                end
            end
            SEQ_DONE: state_n = SEQ_IDLE;
            default:  state_n = SEQ_IDLE;
        endcase
    end

`ifdef WAVE_SEQ_REPEAT_EN
    always_comb begin
        pass_n = pass_idx;
        if (accept)
            pass_n = 8'd0;
        else if (state == SEQ_RUN && !stall && t == LAST && !last_pass)
            pass_n = pass_idx + 8'd1;
        if (state_n != SEQ_RUN)
            pass_n = 8'd0;
    end
`endif

    // Lanes look at the next step so the registered outputs line up with t.
    for (genvar k = 0; k < STAGES; k++) begin : g_lane
        wave_lane #(
            .DEPTH(DEPTH),
            .K    (k),
            .AW   (AW),
            .TW   (TW)
        ) u_lane (
            .t   (t_n),
            .addr(lane_addr[k*AW +: AW]),
            .vld (lane_vld[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEQ_IDLE;
            t        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            finished <= 1'b0;
            addr     <= '0;
            addr_vld <= '0;
`ifdef WAVE_SEQ_REPEAT_EN
            passes_q <= 8'd0;
            pass_idx <= 8'd0;
`endif
        end else begin
            state    <= state_n;
            t        <= t_n;
            busy     <= (state_n == SEQ_RUN);
            done     <= (state_n == SEQ_DONE);
            if (accept)
                finished <= 1'b0;
            else if (state_n == SEQ_DONE)
                finished <= 1'b1;
            addr     <= (state_n == SEQ_RUN) ? lane_addr : '0;
            addr_vld <= (state_n == SEQ_RUN) ? lane_vld : '0;
`ifdef WAVE_SEQ_REPEAT_EN
            if (accept) passes_q <= passes;
            pass_idx <= pass_n;
`endif
        end
    end

endmodule

// File: tb/tb_wave_addr_seq.sv
// Self-checking bench: four wave_addr_seq configurations driven in lockstep against a step-index model.
module tb_wave_addr_seq;

    logic clk = 1'b0;
    logic reset, start, stall;
    logic [7:0] passes;
    logic [3:0] busy, done_o, fin;
    logic [5:0]  a0;  logic [1:0] v0;
    logic [11:0] a1;  logic [3:0] v1;
    logic [1:0]  a2;  logic [0:0] v2;
    logic [3:0]  a3;  logic [1:0] v3;
`ifdef WAVE_SEQ_REPEAT_EN
    logic [7:0] pi0, pi1, pi2, pi3;
`endif

    int checks = 0;
    int failures = 0;

    int dep [4] = '{8, 5, 3, 4};
    int stg [4] = '{2, 4, 1, 2};
    int aw  [4] = '{3, 3, 2, 2};
    // Model: m_s = -2 idle, -1 done cycle, >=0 global step index across passes.
    int m_s [4] = '{-2, -2, -2, -2};
    int m_tot [4] = '{0, 0, 0, 0};
    bit m_fin [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    wave_addr_seq #(.DEPTH(8), .STAGES(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy[0]), .done(done_o[0]), .finished(fin[0]), .addr(a0), .addr_vld(v0)
`ifdef WAVE_SEQ_REPEAT_EN
        , .passes(passes), .pass_idx(pi0)
`endif
    );
    wave_addr_seq #(.DEPTH(5), .STAGES(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy[1]), .done(done_o[1]), .finished(fin[1]), .addr(a1), .addr_vld(v1)
`ifdef WAVE_SEQ_REPEAT_EN
        , .passes(passes), .pass_idx(pi1)
`endif
    );
    wave_addr_seq #(.DEPTH(3), .STAGES(1)) u2 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy[2]), .done(done_o[2]), .finished(fin[2]), .addr(a2), .addr_vld(v2)
`ifdef WAVE_SEQ_REPEAT_EN
        , .passes(passes), .pass_idx(pi2)
`endif
    );
    wave_addr_seq #(.DEPTH(4), .STAGES(2)) u3 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy[3]), .done(done_o[3]), .finished(fin[3]), .addr(a3), .addr_vld(v3)
`ifdef WAVE_SEQ_REPEAT_EN
        , .passes(passes), .pass_idx(pi3)
`endif
    );

    // Word layout: [30]busy [29]done [28]finished [27:20]pass [19:16]vld [15:0] 4 bits per lane
    function automatic logic [31:0] act_word(input int i);
        logic [15:0] ax;
        logic [3:0]  vx;
        logic [7:0]  px;
        logic [31:0] w;
        ax = '0; vx = '0; px = '0;
        case (i)
            0: begin ax = 16'(a0); vx = 4'(v0); end
            1: begin ax = 16'(a1); vx = 4'(v1); end
            2: begin ax = 16'(a2); vx = 4'(v2); end
            default: begin ax = 16'(a3); vx = 4'(v3); end
        endcase
`ifdef WAVE_SEQ_REPEAT_EN
        case (i)
            0: px = pi0;
            1: px = pi1;
            2: px = pi2;
            default: px = pi3;
        endcase
`endif
        w = {1'b0, busy[i], done_o[i], fin[i], px, vx, 16'h0000};
        for (int k = 0; k < stg[i]; k++)
            w[4*k +: 4] = 4'((ax >> (k * aw[i])) & 16'((1 << aw[i]) - 1));
        return w;
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        logic [31:0] w;
        int len, t, p;
        w = '0;
        w[28] = m_fin[i];
        if (m_s[i] == -1) w[29] = 1'b1;
        if (m_s[i] >= 0) begin
            len = dep[i] + stg[i] - 1;
            t = m_s[i] % len;
            p = m_s[i] / len;
            w[30] = 1'b1;
            w[27:20] = 8'(p);
            for (int k = 0; k < stg[i]; k++) begin
                if (t >= k && t - k < dep[i]) begin
                    w[16 + k] = 1'b1;
                    w[4*k +: 4] = 4'(t - k);
                end
            end
        end
        return w;
    endfunction

    // Advance one clock and the model; outputs are settled 1 time unit after the edge.
    task automatic tick();
        int ns [4];
        int nt [4];
        bit nf [4];
        for (int i = 0; i < 4; i++) begin
            ns[i] = m_s[i]; nt[i] = m_tot[i]; nf[i] = m_fin[i];
            if (reset) begin
                ns[i] = -2; nf[i] = 1'b0;
            end else if (m_s[i] == -2) begin
                if (start) begin
                    ns[i] = 0; nf[i] = 1'b0;
`ifdef WAVE_SEQ_REPEAT_EN
                    nt[i] = (dep[i] + stg[i] - 1) * (int'(passes) + 1);
`else
                    nt[i] = dep[i] + stg[i] - 1;
`endif
                end
            end else if (m_s[i] == -1) begin
                ns[i] = -2;
            end else if (!stall) begin
                ns[i] = m_s[i] + 1;
                if (ns[i] == m_tot[i]) begin
                    ns[i] = -1; nf[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            m_s[i] = ns[i]; m_tot[i] = nt[i]; m_fin[i] = nf[i];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; passes = 8'd0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_word(i) !== 32'h0) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, act_word(i), 32'h0);
            end
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_word(i) !== exp_word(i)) begin
                failures++;
                $display("FAIL reset_release dut%0d got=%h exp=%h", i, act_word(i), exp_word(i));
            end
        end
    endtask

    task automatic test_single_pass();
        int nbusy [4] = '{0, 0, 0, 0};
        int req   [4] = '{9, 8, 3, 5};
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (busy[i] === 1'b1) nbusy[i]++;
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL single_pass dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (nbusy[i] != req[i] || fin[i] !== 1'b1) begin
                failures++;
                $display("FAIL run_length dut%0d busy_cycles=%0d exp=%0d finished=%b", i, nbusy[i], req[i], fin[i]);
            end
        end
    endtask

    task automatic test_stall();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (a0 !== 6'o34 || v0 !== 2'b11) begin
                failures++;
                $display("FAIL stall_freeze cyc=%0d got addr=%o vld=%b exp addr=34 vld=11", c, a0, v0);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL stall dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
        end
        stall = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL stall_resume dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int n = 0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        while (done_o[0] !== 1'b1 && n < 20) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL start_ignored dut%0d cyc=%0d got=%h exp=%h", i, n, act_word(i), exp_word(i));
                end
            end
            tick(); n++;
        end
        checks++;
        if (done_o[0] !== 1'b1 || n != 6) begin
            failures++;
            $display("FAIL done_timing got done=%b after %0d cycles exp done=1 after 6", done_o[0], n);
        end
        start = 1'b1; tick();
        tick(); start = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || fin[0] !== 1'b0) begin
            failures++;
            $display("FAIL rearm got busy=%b finished=%b exp busy=1 finished=0", busy[0], fin[0]);
        end
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL rearm_pass dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1; stall = 1'b1; tick(); reset = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_word(i) !== 32'h0) begin
                failures++;
                $display("FAIL reset_mid dut%0d got=%h exp=%h", i, act_word(i), 32'h0);
            end
        end
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL post_reset_pass dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            start  = ($urandom_range(3) == 0);
            stall  = ($urandom_range(2) == 0);
            reset  = ($urandom_range(59) == 0);
            passes = 8'($urandom_range(2));
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
        end
        start = 1'b0; stall = 1'b0; passes = 8'd0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask

`ifdef WAVE_SEQ_REPEAT_EN
    task automatic test_repeat();
        int nbusy = 0;
        int ndone = 0;
        logic [7:0] last_pi = 8'd0;
        passes = 8'd2;
        start = 1'b1; tick(); start = 1'b0;
        passes = 8'd0;
        for (int c = 0; c < 20; c++) begin
            if (busy[3] === 1'b1) begin
                nbusy++;
                last_pi = pi3;
            end
            if (done_o[3] === 1'b1) ndone++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_word(i) !== exp_word(i)) begin
                    failures++;
                    $display("FAIL repeat dut%0d cyc=%0d got=%h exp=%h", i, c, act_word(i), exp_word(i));
                end
            end
            tick();
        end
        checks++;
        if (nbusy != 15 || ndone != 1 || last_pi !== 8'd2) begin
            failures++;
            $display("FAIL repeat_totals got busy=%0d done=%0d pass=%0d exp busy=15 done=1 pass=2", nbusy, ndone, last_pi);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_stall();
        test_start_ignored();
        test_reset_mid();
`ifdef WAVE_SEQ_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
